// File: rtl/inject_queue_if.sv
// Channel/PE bundle for the local injection unit: PE offer handshake, four
// post-ejection channel slots in, four registered channel slots out, status.
`ifndef IN_ROUTER_SIZE
`define IN_ROUTER_SIZE 32
`endif

interface inject_queue_if #(
  parameter int FLIT_W = `IN_ROUTER_SIZE
);
  logic [FLIT_W-1:0] pe_flit;
  logic              pe_valid;
  logic              pe_ready;
  logic [FLIT_W-1:0] in0, in1, in2, in3;
  logic [FLIT_W-1:0] out0, out1, out2, out3;
  logic              inj_fire;
  logic [1:0]        inj_slot;
  logic              starve;

  modport master (
    output pe_flit, pe_valid, in0, in1, in2, in3,
    input  pe_ready, out0, out1, out2, out3, inj_fire, inj_slot, starve
  );

  modport slave (
    input  pe_flit, pe_valid, in0, in1, in2, in3,
    output pe_ready, out0, out1, out2, out3, inj_fire, inj_slot, starve
  );
endinterface

// File: rtl/inject_queue.sv
// Local injection unit: queues PE flits and drops the head into the lowest free
// channel slot; all four channels pass through one register stage.
`ifndef IN_ROUTER_SIZE
`define IN_ROUTER_SIZE 32
`endif

module inject_queue #(
  parameter int FLIT_W       = `IN_ROUTER_SIZE,
  parameter int VALID_IDX    = FLIT_W - 1,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           reset,
  inject_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [7:0]     LIMIT8   = 8'(STARVE_LIMIT);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic [FLIT_W-1:0] out_q [4];
  logic              inj_fire_q;
  logic [1:0]        inj_slot_q;
  logic [7:0]        blk_cnt_q, blk_cnt_d;
  logic              starve_q;

  logic [FLIT_W-1:0] in_flit [4];
  logic [FLIT_W-1:0] enq_flit, head_flit;
  logic [3:0]        free;
  logic [1:0]        sel;
  logic              pe_ready, enq, inject, blocked, fifo_nonempty;

  assign in_flit[0] = bus.in0;
  assign in_flit[1] = bus.in1;
  assign in_flit[2] = bus.in2;
  assign in_flit[3] = bus.in3;

  assign pe_ready      = (count_q != FULL_CNT);
  assign enq           = bus.pe_valid && pe_ready;
  assign fifo_nonempty = (count_q != '0);
  assign head_flit     = mem_q[rd_ptr_q];

  always_comb begin
    enq_flit            = bus.pe_flit;
    enq_flit[VALID_IDX] = 1'b1;
  end

  // Reverse scan so the lowest-indexed free slot wins.
  always_comb begin
    free = '0;
    sel  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      free[i] = ~in_flit[i][VALID_IDX];
      if (free[i]) sel = 2'(i);
    end
  end

  assign inject  = fifo_nonempty && (|free);
  assign blocked = fifo_nonempty && ~(|free);

  always_comb begin
    count_d = count_q;
    case ({enq, inject})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Any cycle that is not blocked either injected or had nothing to send.
  always_comb begin
    blk_cnt_d = '0;
    if (blocked) blk_cnt_d = (blk_cnt_q == 8'hFF) ? blk_cnt_q : blk_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_flit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
      inj_fire_q <= 1'b0;
      inj_slot_q <= 2'd0;
      blk_cnt_q  <= '0;
      starve_q   <= 1'b0;
    end else begin
      if (enq)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (inject) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      for (int i = 0; i < 4; i++)
        out_q[i] <= (inject && sel == 2'(i)) ? head_flit : in_flit[i];
      inj_fire_q <= inject;
      if (inject) inj_slot_q <= sel;
      blk_cnt_q <= blk_cnt_d;
      starve_q  <= (blk_cnt_d >= LIMIT8);
    end
  end

  assign bus.pe_ready = pe_ready;
  assign bus.out0     = out_q[0];
  assign bus.out1     = out_q[1];
  assign bus.out2     = out_q[2];
  assign bus.out3     = out_q[3];
  assign bus.inj_fire = inj_fire_q;
  assign bus.inj_slot = inj_slot_q;
  assign bus.starve   = starve_q;
endmodule
